fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider (result = num1 / num2); the inverse-direction companion of the fp_mul / multiplication datapath.
- Uses restoring mantissa division, one quotient bit per clock, with round-to-nearest-even.
- Valid/ready handshake on input and output so it can share the operand bus used by the multiplier.
- Flush-to-zero: denormal inputs are read as zero, and underflowing results become signed zero.

Parameters:
- ROUND_EN, 1: 1 = round-to-nearest-even; 0 = truncate (guard and sticky ignored).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- num1  in  32  dividend, fp32.
- num2  in  32  divisor, fp32.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- result  out  32  quotient, fp32.
- flags  out  4  {invalid, div_by_zero, overflow, underflow}; valid while out_valid is high.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, all internal registers cleared. Reset mid-operation abandons the division; no result is emitted.
- States: IDLE -> PREP -> ITER -> ROUND -> DONE -> IDLE.
- Operand accept: in_valid && in_ready at a rising edge registers num1/num2 and moves to PREP. in_ready = (state==IDLE). Input changes after accept have no effect.
- PREP (1 cycle): unpack both operands, classify them, compute sign = s1^s2.
  - Special cases go straight to DONE, in this priority order:
  - NaN operand -> 32'h7FC00000.
  - 0/0 or inf/inf -> 32'h7FC00000, invalid=1.
  - inf/x -> signed inf.
  - x/0 (x nonzero finite) -> signed inf, div_by_zero=1.
  - 0/x or x/inf -> signed zero.
  - Normal case: rem = {1'b0, 1.m1} (25b), den = 1.m2 (24b), exp = e1 - e2 + 127 as a 10-bit signed value, iter counter = 26.
- ITER (27 cycles): each cycle, if rem >= den then q_bit=1 and rem -= den, else q_bit=0; then rem <<= 1 and shift q_bit into q[26:0]. Counter decrements; leaving at counter==0.
- ROUND (1 cycle):
  - Normalise: if q[26]=1, mant=q[26:3], g=q[2], s=|q[1:0] | (rem!=0). Otherwise mant=q[25:2], g=q[1], s=q[0] | (rem!=0), exp -= 1.
  - RNE: increment mant when g && (s || mant[0]). A carry out of 24'hFFFFFF gives mant=24'h800000 and exp += 1.
  - exp >= 255 -> signed inf, overflow=1. exp <= 0 -> signed zero, underflow=1. Otherwise result = {sign, exp[7:0], mant[22:0]}.
- DONE: out_valid=1. result and flags are held stable until out_valid && out_ready, then state returns to IDLE with out_valid=0 and in_ready=1 in the following cycle. There is no same-cycle accept of new operands in DONE.
- Latency, counted from the accepting edge to the edge that raises out_valid:
  - Normal operands: 30 edges (PREP 1 + ITER 27 + ROUND 1 + 1).
  - Special cases: 2 edges.
- Throughput: one operation in flight; no pipelining.

Decomposition:
- Package fp_pkg holds:
  - fp32_t packed struct {sign, exp[7:0], frac[22:0]}.
  - Constants FP_BIAS=127, FP_QNAN=32'h7FC00000, FP_EXP_MAX=8'hFF.
  - State enum div_state_t {IDLE, PREP, ITER, ROUND, DONE}.
  - Class enum fp_class_t {ZERO, NORMAL, INF, NAN}.
- Sub-module fp_classify: combinational, fp32 in, fp_class_t out. Two instances are used in PREP.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> result=0x40400000, flags=0, out_valid exactly 30 edges after accept.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with ROUND_EN=1; 0x3EAAAAAA with ROUND_EN=0.
- 0xBF800000 / 0x00000000 -> 0xFF800000, div_by_zero=1, 2-edge latency. 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1.
- 0x7F000000 / 0x00800000 -> 0x7F800000, overflow=1. 0x00800000 / 0x7F000000 -> 0x00000000, underflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - result, flags and out_valid stay stable; in_ready stays 0; in_valid pulses are ignored.
  - Then out_ready=1 for 1 cycle: next cycle out_valid=0, in_ready=1.
- Assert rst at ITER cycle 10 -> out_valid=0 and in_ready=1 immediately (asynchronous). A new 6.0/2.0 after deassert returns 0x40400000 in 30 edges.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared fp32 types, constants and state/class encodings for the
// sequential divider.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

    // Quotient bits produced: 1 integer bit + 23 fraction + guard + 2 extra.
    localparam logic [4:0]  DIV_ITER_START = 5'd26;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        ROUND,
        DONE
    } div_state_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    // Build an fp32 bit pattern from its fields.
    function automatic logic [31:0] fp_pack(input logic sign, input logic [7:0] exp,
                                            input logic [22:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational fp32 operand classifier; denormals are read as zero.
import fp_pkg::*;

module fp_classify (
    input  fp32_t     operand,
    output fp_class_t op_class
);

    // Decode exponent/fraction into a class (flush-to-zero for exp==0).
    always_comb begin
        op_class = NORMAL;
        if (operand.exp == 8'h00) begin
            op_class = ZERO;
        end else if (operand.exp == FP_EXP_MAX) begin
            op_class = (operand.frac == 23'd0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential fp32 divider: restoring mantissa division, one quotient bit
// per clock, round-to-nearest-even (or truncate), flush-to-zero.
import fp_pkg::*;

module fp_div_seq #(
    parameter int unsigned ROUND_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    div_state_t         state;
    fp32_t              n1_r;
    fp32_t              n2_r;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [24:0]        rem_r;
    logic [23:0]        den_r;
    logic [26:0]        q_r;
    logic [4:0]         cnt_r;

    fp_class_t          cls1;
    fp_class_t          cls2;

    fp_classify u_cls1 (
        .operand  (n1_r),
        .op_class (cls1)
    );

    fp_classify u_cls2 (
        .operand  (n2_r),
        .op_class (cls2)
    );

    logic               sign_w;
    logic signed [9:0]  exp_w;
    logic               spec_hit;
    logic [31:0]        spec_res;
    logic [3:0]         spec_flags;

    // Special-operand decision, evaluated on the registered operands in PREP.
    always_comb begin
        sign_w     = n1_r.sign ^ n2_r.sign;
        exp_w      = $signed({2'b00, n1_r.exp}) - $signed({2'b00, n2_r.exp})
                     + $signed(10'(FP_BIAS));
        spec_hit   = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (cls1 == NAN || cls2 == NAN) begin
            spec_res = FP_QNAN;
        end else if ((cls1 == ZERO && cls2 == ZERO) || (cls1 == INF && cls2 == INF)) begin
            spec_res   = FP_QNAN;
            spec_flags = 4'b1000;
        end else if (cls1 == INF) begin
            spec_res = fp_pack(sign_w, FP_EXP_MAX, 23'd0);
        end else if (cls2 == ZERO) begin
            spec_res   = fp_pack(sign_w, FP_EXP_MAX, 23'd0);
            spec_flags = 4'b0100;
        end else if (cls1 == ZERO || cls2 == INF) begin
            spec_res = fp_pack(sign_w, 8'h00, 23'd0);
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic               q_bit;
    logic [24:0]        rem_diff;
    logic [24:0]        rem_next;

    // One restoring-division step: compare, conditionally subtract, shift.
    always_comb begin
        q_bit    = (rem_r >= {1'b0, den_r});
        rem_diff = q_bit ? (rem_r - {1'b0, den_r}) : rem_r;
        rem_next = rem_diff << 1;
    end

    logic [23:0]        mant;
    logic               g_bit;
    logic               s_bit;
    logic signed [9:0]  e_n;
    logic [24:0]        mant_sum;
    logic [31:0]        rnd_res;
    logic [3:0]         rnd_flags;

    // Normalise the quotient, apply rounding, then range-check the exponent.
    always_comb begin
        mant_sum  = '0;
        rnd_res   = '0;
        rnd_flags = '0;
        if (q_r[26]) begin
            mant  = q_r[26:3];
            g_bit = q_r[2];
            s_bit = (|q_r[1:0]) | (rem_r != 25'd0);
            e_n   = exp_r;
        end else begin
            mant  = q_r[25:2];
            g_bit = q_r[1];
            s_bit = q_r[0] | (rem_r != 25'd0);
            e_n   = exp_r - 10'sd1;
        end
        if (ROUND_EN != 0 && g_bit && (s_bit || mant[0])) begin
            mant_sum = {1'b0, mant} + 25'd1;
            if (mant_sum[24]) begin
                mant = 24'h800000;
                e_n  = e_n + 10'sd1;
            end else begin
                mant = mant_sum[23:0];
            end
        end
        if (e_n >= 10'sd255) begin
            rnd_res   = fp_pack(sign_r, FP_EXP_MAX, 23'd0);
            rnd_flags = 4'b0010;
        end else if (e_n <= 10'sd0) begin
            rnd_res   = fp_pack(sign_r, 8'h00, 23'd0);
            rnd_flags = 4'b0001;
        end else begin
            rnd_res   = fp_pack(sign_r, e_n[7:0], mant[22:0]);
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            n1_r      <= '0;
            n2_r      <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            rem_r     <= '0;
            den_r     <= '0;
            q_r       <= '0;
            cnt_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n1_r     <= num1;
                        n2_r     <= num2;
                        in_ready <= 1'b0;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    sign_r <= sign_w;
                    if (spec_hit) begin
                        result    <= spec_res;
                        flags     <= spec_flags;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem_r <= {2'b01, n1_r.frac};
                        den_r <= {1'b1, n2_r.frac};
                        exp_r <= exp_w;
                        q_r   <= '0;
                        cnt_r <= DIV_ITER_START;
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem_r <= rem_next;
                    q_r   <= {q_r[25:0], q_bit};
                    if (cnt_r == 5'd0) begin
                        state <= ROUND;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                ROUND: begin
                    result    <= rnd_res;
                    flags     <= rnd_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed, table-driven bench for fp_div_seq (rounding and truncating builds).
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] num1 = '0;
    logic [31:0] num2 = '0;
    logic        out_ready = 1'b1;

    logic        in_ready,  out_valid;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        t_in_ready, t_out_valid;
    logic [31:0] t_result;
    logic [3:0]  t_flags;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.ROUND_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_div_seq #(.ROUND_EN(0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .num1(num1), .num2(num2), .out_valid(t_out_valid), .out_ready(out_ready),
        .result(t_result), .flags(t_flags)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_rne;
        logic [31:0] exp_trn;
        logic [3:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Apply one operation; returns once out_valid is seen (#1 after its edge).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [31:0] rt,
                          output logic [3:0] f, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        num1 = a;
        num2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num1 = 32'hDEADBEEF;
        num2 = 32'h12345678;
        lat = 1;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        r  = result;
        rt = t_result;
        f  = flags;
    endtask

    initial begin
        logic [31:0] r, rt;
        logic [3:0]  f;
        int          lat;

        vecs[0]  = '{"6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000, 30};
        vecs[1]  = '{"1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 4'b0000, 30};
        vecs[2]  = '{"-1/0",      32'hBF800000, 32'h00000000, 32'hFF800000, 32'hFF800000, 4'b0100, 2};
        vecs[3]  = '{"0/0",       32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'b1000, 2};
        vecs[4]  = '{"ovf",       32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7F800000, 4'b0010, 30};
        vecs[5]  = '{"unf",       32'h00800000, 32'h7F000000, 32'h00000000, 32'h00000000, 4'b0001, 30};
        vecs[6]  = '{"-6/2",      32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 4'b0000, 30};
        vecs[7]  = '{"inf/inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 4'b1000, 2};
        vecs[8]  = '{"nan/1",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'b0000, 2};
        vecs[9]  = '{"inf/-2",    32'h7F800000, 32'hC0000000, 32'hFF800000, 32'hFF800000, 4'b0000, 2};
        vecs[10] = '{"den/1",     32'h00000001, 32'h3F800000, 32'h00000000, 32'h00000000, 4'b0000, 2};
        vecs[11] = '{"1/den",     32'h3F800000, 32'h00000005, 32'h7F800000, 32'h7F800000, 4'b0100, 2};
        vecs[12] = '{"2/-inf",    32'h40000000, 32'hFF800000, 32'h80000000, 32'h80000000, 4'b0000, 2};
        vecs[13] = '{"1/1",       32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 30};
        vecs[14] = '{"1/2",       32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 4'b0000, 30};

        // Asynchronous reset: outputs take reset values before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_flags",     {28'd0, flags},     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].a, vecs[i].b, r, rt, f, lat);
            check({vecs[i].name, " result"},  r,            vecs[i].exp_rne);
            check({vecs[i].name, " trunc"},   rt,           vecs[i].exp_trn);
            check({vecs[i].name, " flags"},   {28'd0, f},   {28'd0, vecs[i].exp_flags});
            check({vecs[i].name, " latency"}, lat,          vecs[i].exp_lat);
            @(posedge clk);
            #1;
            check({vecs[i].name, " release"}, {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Backpressure: result held, operands ignored, then one-cycle release.
        out_ready = 1'b0;
        run_op(32'h40C00000, 32'h40000000, r, rt, f, lat);
        check("bp latency", lat, 30);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            num1 = 32'h3F800000;
            num2 = 32'h40400000;
            in_valid = (c % 2 == 0);
            @(posedge clk);
            #1;
            check("bp out_valid", {31'd0, out_valid}, 32'd1);
            check("bp in_ready",  {31'd0, in_ready},  32'd0);
            check("bp result",    result,             32'h40400000);
            check("bp flags",     {28'd0, flags},     32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp drain out_valid", {31'd0, out_valid}, 32'd0);
        check("bp drain in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        check("bp idle in_ready", {31'd0, in_ready}, 32'd1);

        // Reset during ITER abandons the division.
        @(negedge clk);
        num1 = 32'h40C00000;
        num2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        check("mid in_ready before rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        check("mid no result", {31'd0, out_valid}, 32'd0);
        run_op(32'h40C00000, 32'h40000000, r, rt, f, lat);
        check("post rst result",  r,   32'h40400000);
        check("post rst latency", lat, 30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
